// File: rtl/fixed_accum_if.sv
// rtl/fixed_accum_if.sv - operand stream in, saturated result out, valid/ready on both sides
interface fixed_accum_if #(
  parameter int W = 32
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_ovf;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_ovf, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_ovf, out_valid
  );
endinterface

// File: rtl/fixed_accum.sv
// rtl/fixed_accum.sv - sign-magnitude Q(M.N) accumulator with guard bits and saturated result
module fixed_accum #(
  parameter int N = 23,
  parameter int M = 8,
  parameter int G = 4
) (
  input  logic          clk,
  input  logic          rst,
  fixed_accum_if.slave  bus
);
  localparam int W = N + M + 1;
  localparam int A = W + G;
  localparam logic [A-1:0] A_MAX = {1'b0, {(A-1){1'b1}}};
  localparam logic [A-1:0] A_MIN = {1'b1, {(A-1){1'b0}}};

  typedef enum logic {ACC, DONE} state_t;

  state_t       state_q, state_d;
  logic [A-1:0] acc_q, acc_d;
  logic         ovf_q, ovf_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         out_ovf_q, out_ovf_d;

  logic [A-1:0] mag_ext, value, sum_raw, sum, abs_s;
  logic         add_ovf, sat;
  logic [W-1:0] sat_data;

  // Negating a zero magnitude yields zero, so negative zero needs no special case.
  always_comb begin
    mag_ext  = {{(G+1){1'b0}}, bus.in_data[W-2:0]};
    value    = bus.in_data[W-1] ? -mag_ext : mag_ext;
    sum_raw  = acc_q + value;
    add_ovf  = (acc_q[A-1] == value[A-1]) && (sum_raw[A-1] != acc_q[A-1]);
    sum      = add_ovf ? (acc_q[A-1] ? A_MIN : A_MAX) : sum_raw;
    abs_s    = sum[A-1] ? -sum : sum;
    sat      = |abs_s[A-1:W-1];
    sat_data = sat ? {sum[A-1], {(W-1){1'b1}}} : {sum[A-1], abs_s[W-2:0]};
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      ACC: begin
        if (bus.in_valid) begin
          if (bus.in_last) begin
            out_data_d  = sat_data;
            out_ovf_d   = ovf_q | add_ovf | sat;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            acc_d = sum;
            ovf_d = ovf_q | add_ovf;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          ovf_d       = 1'b0;
          state_d     = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACC;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_fixed_accum.sv
// tb/tb_fixed_accum.sv - directed-vector bench for fixed_accum (N=23, M=8, G=4)
module tb_fixed_accum;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  fixed_accum_if #(.W(32)) bus ();

  fixed_accum #(.N(23), .M(8), .G(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_beat(input logic [31:0] d, input logic l);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = l;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic ack_result;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_ovf !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h ovf=%b ready=%b required 0/00000000/0/1",
               bus.out_valid, bus.out_data, bus.out_ovf, bus.in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_sum;
    send_beat(32'h0080_0000, 1'b0);
    send_beat(32'h0080_0000, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid: out_valid=%b required 0", bus.out_valid);
    end
    send_beat(32'h8040_0000, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00C0_0000 || bus.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum: valid=%b data=%h ovf=%b required 1/00c00000/0",
               bus.out_valid, bus.out_data, bus.out_ovf);
    end
    ack_result();
  endtask

  task automatic test_saturation;
    send_beat(32'h6400_0000, 1'b0);
    send_beat(32'h3200_0000, 1'b1);
    checks++;
    if (bus.out_data !== 32'h7FFF_FFFF || bus.out_ovf !== 1'b1) begin
      errors++;
      $display("FAIL pos_sat: data=%h ovf=%b required 7fffffff/1", bus.out_data, bus.out_ovf);
    end
    ack_result();
    send_beat(32'h0080_0000, 1'b1);
    checks++;
    if (bus.out_data !== 32'h0080_0000 || bus.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear: data=%h ovf=%b required 00800000/0", bus.out_data, bus.out_ovf);
    end
    ack_result();
    send_beat(32'hE400_0000, 1'b0);
    send_beat(32'hB200_0000, 1'b1);
    checks++;
    if (bus.out_data !== 32'hFFFF_FFFF || bus.out_ovf !== 1'b1) begin
      errors++;
      $display("FAIL neg_sat: data=%h ovf=%b required ffffffff/1", bus.out_data, bus.out_ovf);
    end
    ack_result();
  endtask

  // 17 negative full-scale beats clamp the accumulator at -2^35; 16 positive ones then leave -16.
  task automatic test_guard_overflow;
    for (int i = 0; i < 17; i++) send_beat(32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 15; i++) send_beat(32'h7FFF_FFFF, 1'b0);
    send_beat(32'h7FFF_FFFF, 1'b1);
    checks++;
    if (bus.out_data !== 32'h8000_0010 || bus.out_ovf !== 1'b1) begin
      errors++;
      $display("FAIL guard_ovf: data=%h ovf=%b required 80000010/1", bus.out_data, bus.out_ovf);
    end
    ack_result();
  endtask

  task automatic test_cancel_negzero;
    send_beat(32'h0180_0000, 1'b0);
    send_beat(32'h8180_0000, 1'b1);
    checks++;
    if (bus.out_data !== 32'h0 || bus.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL cancel: data=%h ovf=%b required 00000000/0", bus.out_data, bus.out_ovf);
    end
    ack_result();
    send_beat(32'h0100_0000, 1'b1);
    ack_result();
    send_beat(32'h8000_0000, 1'b1);
    checks++;
    if (bus.out_data !== 32'h0 || bus.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL neg_zero: data=%h ovf=%b required 00000000/0", bus.out_data, bus.out_ovf);
    end
    ack_result();
  endtask

  task automatic test_backpressure;
    send_beat(32'h0080_0000, 1'b1);
    bus.in_data  = 32'h0080_0000;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 32'h0080_0000) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: ready=%b valid=%b data=%h required 0/1/00800000",
                 i, bus.in_ready, bus.out_valid, bus.out_data);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 32'h0080_0000) begin
      errors++;
      $display("FAIL backpressure_release: valid=%b ready=%b data=%h required 0/1/00800000",
               bus.out_valid, bus.in_ready, bus.out_data);
    end
    send_beat(32'h0040_0000, 1'b1);
    checks++;
    if (bus.out_data !== 32'h0040_0000) begin
      errors++;
      $display("FAIL backpressure_no_accept: data=%h required 00400000", bus.out_data);
    end
    ack_result();
  endtask

  task automatic test_gapped;
    send_beat(32'h0080_0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    send_beat(32'h8080_0000, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL gap_idle: valid=%b ready=%b required 0/1", bus.out_valid, bus.in_ready);
    end
    send_beat(32'h0020_0000, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0020_0000 || bus.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL gapped: valid=%b data=%h ovf=%b required 1/00200000/0",
               bus.out_valid, bus.out_data, bus.out_ovf);
    end
    ack_result();
  endtask

  task automatic test_reset_mid_sum;
    send_beat(32'h0080_0000, 1'b0);
    send_beat(32'h0080_0000, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_data !== 32'h0 || bus.out_valid !== 1'b0 || bus.out_ovf !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_sum: data=%h valid=%b ovf=%b ready=%b required 00000000/0/0/1",
               bus.out_data, bus.out_valid, bus.out_ovf, bus.in_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    send_beat(32'h0040_0000, 1'b1);
    checks++;
    if (bus.out_data !== 32'h0040_0000 || bus.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: data=%h ovf=%b required 00400000/0", bus.out_data, bus.out_ovf);
    end
    ack_result();
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic_sum();
    test_saturation();
    test_guard_overflow();
    test_cancel_negzero();
    test_backpressure();
    test_gapped();
    test_reset_mid_sum();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
